// File: rtl/atm_pkg.sv
// atm_pkg: shared encodings for the ATM session front end.
//   Op codes, keypad codes, prompt encodings, session state enum and
//   the prompt-per-state helper used by atm_session_ctrl.
package atm_pkg;

    localparam int unsigned ACC_W      = 4;
    localparam int unsigned PIN_W      = 16;
    localparam int unsigned AMT_W      = 32;
    localparam int unsigned PIN_DIGITS = 4;

    // ATM operation codes
    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_WITHDRAW = 3'd4;
    localparam logic [2:0] OP_DEPOSIT  = 3'd5;
    localparam logic [2:0] OP_CHPIN    = 3'd6;

    // Keypad control codes (0-9 are digits)
    localparam logic [3:0] KEY_ENTER  = 4'd10;
    localparam logic [3:0] KEY_CLEAR  = 4'd11;
    localparam logic [3:0] KEY_CANCEL = 4'd12;

    // Prompt encodings
    localparam logic [2:0] PROMPT_CARD   = 3'd0;
    localparam logic [2:0] PROMPT_PIN    = 3'd1;
    localparam logic [2:0] PROMPT_OP     = 3'd2;
    localparam logic [2:0] PROMPT_AMT    = 3'd3;
    localparam logic [2:0] PROMPT_NEWPIN = 3'd4;
    localparam logic [2:0] PROMPT_WAIT   = 3'd5;

    // ATM core state while held in reset
    localparam logic [2:0] ATM_IDLE_STATE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_GET_PIN    = 3'd1,
        S_GET_OP     = 3'd2,
        S_GET_AMT    = 3'd3,
        S_GET_NEWPIN = 3'd4,
        S_ISSUE      = 3'd5,
        S_WAIT       = 3'd6,
        S_REPORT     = 3'd7
    } state_e;

    // Which input the user is expected to provide in a given state
    function automatic logic [2:0] prompt_of(input state_e s);
        logic [2:0] p;
        p = PROMPT_WAIT;
        case (s)
            S_IDLE:       p = PROMPT_CARD;
            S_GET_PIN:    p = PROMPT_PIN;
            S_GET_OP:     p = PROMPT_OP;
            S_GET_AMT:    p = PROMPT_AMT;
            S_GET_NEWPIN: p = PROMPT_NEWPIN;
            default:      p = PROMPT_WAIT;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/atm_dec_accum.sv
// atm_dec_accum: decimal digit accumulator (value = value*10 + digit).
//   clk, rst         : clock, synchronous active-low reset
//   clear_i          : zero value and digit count
//   clear_ovf_i      : clear the sticky overflow flag
//   digit_valid_i    : digit strobe, digit_i in 0..9
//   value_o          : accumulated binary value
//   count_o          : digits accepted so far
//   ovf_o            : sticky, a digit arrived after MAX_DIGITS were taken
module atm_dec_accum #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear_i,
    input  logic                                 clear_ovf_i,
    input  logic                                 digit_valid_i,
    input  logic [3:0]                           digit_i,
    output logic [WIDTH-1:0]                     value_o,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      count_o,
    output logic                                 ovf_o
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    logic [WIDTH-1:0] value_q, value_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [33:0]      mac;

    // Accumulate in 34 bits; digit limit guarantees the result fits WIDTH
    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mac     = 34'(value_q) * 34'd10 + 34'(digit_i);
        if (clear_i) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (digit_valid_i) begin
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                value_d = WIDTH'(mac);
                cnt_d   = cnt_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value_o = value_q;
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: user-side session controller in front of the ATM core.
//   Collects card, PIN, operation, amount / new PIN from the keypad, then
//   releases the ATM (atm_rst=1) for HOLD_CYCLES with a stable request,
//   captures balance/success on the last hold cycle and reports the result.
//   clk, rst                       : clock, synchronous active-low reset
//   card_valid/card_acc/card_lang  : card reader strobe and data
//   key_valid/key_code             : keypad strobe and code
//   atm_balance/success/state      : ATM core outputs (state is debug only)
//   atm_rst, atm_*                 : registered request to the ATM core
//   busy, prompt, done, aborted    : session status
//   result_success/balance         : captured ATM result
//   amt_overflow                   : amount digits were dropped this session
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned AMT_DIGITS     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_valid,
    input  logic [ACC_W-1:0] card_acc,
    input  logic             card_lang,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic [AMT_W-1:0] atm_balance,
    input  logic             atm_success,
    input  logic [2:0]       atm_state,
    output logic             atm_rst,
    output logic [2:0]       atm_operation,
    output logic [ACC_W-1:0] atm_acc_num,
    output logic [PIN_W-1:0] atm_pin,
    output logic [PIN_W-1:0] atm_new_pin,
    output logic [AMT_W-1:0] atm_amount,
    output logic             atm_language,
    output logic             busy,
    output logic [2:0]       prompt,
    output logic             done,
    output logic             aborted,
    output logic             result_success,
    output logic [AMT_W-1:0] result_balance,
    output logic             amt_overflow
);

    localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PIN_CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int unsigned AMT_CNT_W = $clog2(AMT_DIGITS + 1);

    state_e state_q, state_d;
    logic   abort_c;

    logic [HOLD_W-1:0] hold_q;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [2:0]        op_q;
    logic              hold_last;

    logic              atm_rst_q, atm_rst_d;
    logic              busy_q, busy_d;
    logic [2:0]        prompt_q, prompt_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic [2:0]        atm_op_q;
    logic [ACC_W-1:0]  acc_q;
    logic              lang_q;
    logic [PIN_W-1:0]  atm_pin_q, atm_new_pin_q;
    logic [AMT_W-1:0]  atm_amount_q;
    logic              res_success_q;
    logic [AMT_W-1:0]  res_balance_q;

    logic [PIN_W-1:0]     pin_val, newpin_val;
    logic [AMT_W-1:0]     amt_val;
    logic [PIN_CNT_W-1:0] pin_cnt, newpin_cnt;
    logic [AMT_CNT_W-1:0] unused_amt_cnt;
    logic                 unused_pin_ovf, unused_newpin_ovf;
    logic                 amt_ovf;
    logic                 unused_atm_state;

    // Keypad / card decode
    logic key_digit, key_enter, key_clear, key_cancel;
    logic card_take, tmo_hit, entry_state;

    assign key_digit   = key_valid && (key_code <= 4'd9);
    assign key_enter   = key_valid && (key_code == KEY_ENTER);
    assign key_clear   = key_valid && (key_code == KEY_CLEAR);
    assign key_cancel  = key_valid && (key_code == KEY_CANCEL);
    assign card_take   = (state_q == S_IDLE) && card_valid;
    assign entry_state = (state_q == S_GET_PIN) || (state_q == S_GET_OP) ||
                         (state_q == S_GET_AMT) || (state_q == S_GET_NEWPIN);
    assign tmo_hit     = entry_state && !key_valid &&
                         (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign hold_last   = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
    assign unused_atm_state = ^atm_state;

    // Digit accumulators: current PIN, new PIN, amount
    atm_dec_accum #(.WIDTH(PIN_W), .MAX_DIGITS(PIN_DIGITS)) u_pin (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (card_take || ((state_q == S_GET_PIN) && key_clear)),
        .clear_ovf_i   (card_take),
        .digit_valid_i ((state_q == S_GET_PIN) && key_digit),
        .digit_i       (key_code),
        .value_o       (pin_val),
        .count_o       (pin_cnt),
        .ovf_o         (unused_pin_ovf)
    );

    atm_dec_accum #(.WIDTH(PIN_W), .MAX_DIGITS(PIN_DIGITS)) u_newpin (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (card_take || ((state_q == S_GET_NEWPIN) && key_clear)),
        .clear_ovf_i   (card_take),
        .digit_valid_i ((state_q == S_GET_NEWPIN) && key_digit),
        .digit_i       (key_code),
        .value_o       (newpin_val),
        .count_o       (newpin_cnt),
        .ovf_o         (unused_newpin_ovf)
    );

    atm_dec_accum #(.WIDTH(AMT_W), .MAX_DIGITS(AMT_DIGITS)) u_amt (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (card_take || ((state_q == S_GET_AMT) && key_clear)),
        .clear_ovf_i   (card_take),
        .digit_valid_i ((state_q == S_GET_AMT) && key_digit),
        .digit_i       (key_code),
        .value_o       (amt_val),
        .count_o       (unused_amt_cnt),
        .ovf_o         (amt_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cancel wins over timeout and other keys
    always_comb begin
        state_d = state_q;
        abort_c = 1'b0;
        if (entry_state && (key_cancel || tmo_hit)) begin
            state_d = S_IDLE;
            abort_c = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (card_valid) state_d = S_GET_PIN;
                end
                S_GET_PIN: begin
                    if (key_enter && (pin_cnt == PIN_CNT_W'(PIN_DIGITS))) state_d = S_GET_OP;
                end
                S_GET_OP: begin
                    if (key_digit) begin
                        case (key_code[2:0])
                            OP_BALANCE:  if (key_code[3] == 1'b0) state_d = S_ISSUE;
                            OP_WITHDRAW,
                            OP_DEPOSIT:  if (key_code[3] == 1'b0) state_d = S_GET_AMT;
                            OP_CHPIN:    if (key_code[3] == 1'b0) state_d = S_GET_NEWPIN;
                            default:     state_d = state_q;
                        endcase
                    end
                end
                S_GET_AMT: begin
                    if (key_enter) state_d = S_ISSUE;
                end
                S_GET_NEWPIN: begin
                    if (key_enter && (newpin_cnt == PIN_CNT_W'(PIN_DIGITS))) state_d = S_ISSUE;
                end
                S_ISSUE:  state_d = S_WAIT;
                S_WAIT:   if (hold_last) state_d = S_REPORT;
                S_REPORT: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state, registered below
    always_comb begin
        atm_rst_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        prompt_d  = prompt_of(state_d);
        atm_rst_d = (state_d == S_WAIT);
        done_d    = (state_d == S_REPORT);
        aborted_d = abort_c;
        busy_d    = (state_d != S_IDLE) && (state_d != S_REPORT);
        // Idle timer restarts on any key and on every state change
        tmo_d     = (key_valid || (state_d != state_q)) ? '0 : tmo_q + TMO_W'(1);
    end

    // Registered outputs and session datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            atm_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
            prompt_q      <= PROMPT_CARD;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            hold_q        <= '0;
            tmo_q         <= '0;
            op_q          <= '0;
            atm_op_q      <= '0;
            acc_q         <= '0;
            lang_q        <= 1'b0;
            atm_pin_q     <= '0;
            atm_new_pin_q <= '0;
            atm_amount_q  <= '0;
            res_success_q <= 1'b0;
            res_balance_q <= '0;
        end else begin
            atm_rst_q <= atm_rst_d;
            busy_q    <= busy_d;
            prompt_q  <= prompt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            tmo_q     <= tmo_d;
            hold_q    <= (state_q == S_WAIT) ? hold_q + HOLD_W'(1) : '0;
            if (card_take) begin
                acc_q  <= card_acc;
                lang_q <= card_lang;
            end
            if ((state_q == S_GET_OP) && key_digit) begin
                op_q <= key_code[2:0];
            end
            // Request fields frozen one cycle before the ATM is released
            if (state_q == S_ISSUE) begin
                atm_op_q      <= op_q;
                atm_pin_q     <= pin_val;
                atm_new_pin_q <= newpin_val;
                atm_amount_q  <= amt_val;
            end
            if ((state_q == S_WAIT) && hold_last) begin
                res_success_q <= atm_success;
                res_balance_q <= atm_balance;
            end
        end
    end

    assign atm_rst        = atm_rst_q;
    assign atm_operation  = atm_op_q;
    assign atm_acc_num    = acc_q;
    assign atm_pin        = atm_pin_q;
    assign atm_new_pin    = atm_new_pin_q;
    assign atm_amount     = atm_amount_q;
    assign atm_language   = lang_q;
    assign busy           = busy_q;
    assign prompt         = prompt_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign result_success = res_success_q;
    assign result_balance = res_balance_q;
    assign amt_overflow   = amt_ovf;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed bench for atm_session_ctrl with a small
// behavioural ATM core (account 1: PIN 1234, balance 1500;
// account 2: PIN 2345, balance 2500).
module tb_atm_session_ctrl;
    import atm_pkg::*;

    localparam int unsigned HOLD = 4;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned AMTD = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_valid;
    logic [3:0]  card_acc;
    logic        card_lang;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] atm_balance;
    logic        atm_success;
    logic [2:0]  atm_state;
    logic        atm_rst;
    logic [2:0]  atm_operation;
    logic [3:0]  atm_acc_num;
    logic [15:0] atm_pin;
    logic [15:0] atm_new_pin;
    logic [31:0] atm_amount;
    logic        atm_language;
    logic        busy;
    logic [2:0]  prompt;
    logic        done;
    logic        aborted;
    logic        result_success;
    logic [31:0] result_balance;
    logic        amt_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    atm_session_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO),
        .AMT_DIGITS    (AMTD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .card_valid    (card_valid),
        .card_acc      (card_acc),
        .card_lang     (card_lang),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .atm_balance   (atm_balance),
        .atm_success   (atm_success),
        .atm_state     (atm_state),
        .atm_rst       (atm_rst),
        .atm_operation (atm_operation),
        .atm_acc_num   (atm_acc_num),
        .atm_pin       (atm_pin),
        .atm_new_pin   (atm_new_pin),
        .atm_amount    (atm_amount),
        .atm_language  (atm_language),
        .busy          (busy),
        .prompt        (prompt),
        .done          (done),
        .aborted       (aborted),
        .result_success(result_success),
        .result_balance(result_balance),
        .amt_overflow  (amt_overflow)
    );

    // Behavioural ATM core: idle (state 7, zero outputs) while atm_rst=0
    logic [31:0] base;
    logic        pin_ok;
    always_comb begin
        atm_balance = '0;
        atm_success = 1'b0;
        atm_state   = ATM_IDLE_STATE;
        base        = '0;
        pin_ok      = 1'b0;
        if (atm_rst) begin
            atm_state = 3'd0;
            case (atm_acc_num)
                4'd1: begin base = 32'd1500; pin_ok = (atm_pin == 16'd1234); end
                4'd2: begin base = 32'd2500; pin_ok = (atm_pin == 16'd2345); end
                default: ;
            endcase
            case (atm_operation)
                OP_BALANCE: begin atm_balance = base; atm_success = pin_ok; end
                OP_WITHDRAW: begin
                    if (pin_ok && (atm_amount <= base)) begin
                        atm_balance = base - atm_amount;
                        atm_success = 1'b1;
                    end else begin
                        atm_balance = base;
                    end
                end
                OP_DEPOSIT: begin atm_balance = base + atm_amount; atm_success = pin_ok; end
                OP_CHPIN:   begin atm_balance = base; atm_success = pin_ok; end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic press4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic insert(input logic [3:0] acc, input logic lang,
                          input logic with_key, input logic [3:0] k);
        @(negedge clk);
        card_valid = 1'b1;
        card_acc   = acc;
        card_lang  = lang;
        key_valid  = with_key;
        key_code   = k;
        @(negedge clk);
        card_valid = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'd0;
    endtask

    // Watch the hold window that follows an accepting key press
    task automatic observe(input string tag, input logic [2:0] op, input logic [3:0] acc,
                           input logic [15:0] pin, input logic [15:0] npin,
                           input logic [31:0] amt);
        int rise    = -1;
        int done_at = -1;
        int hi      = 0;
        int dn      = 0;
        int ab      = 0;
        bit fok     = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (atm_rst) begin
                if (rise < 0) rise = i;
                hi++;
                if (atm_operation !== op || atm_acc_num !== acc || atm_pin !== pin ||
                    atm_new_pin !== npin || atm_amount !== amt) fok = 1'b0;
            end
            if (done) begin
                dn++;
                if (done_at < 0) done_at = i;
            end
            if (aborted) ab++;
        end
        check({tag, "_rise"},   32'(rise),    32'd1);
        check({tag, "_hold"},   32'(hi),      32'(HOLD));
        check({tag, "_doneat"}, 32'(done_at), 32'(HOLD + 1));
        check({tag, "_ndone"},  32'(dn),      32'd1);
        check({tag, "_fields"}, 32'(fok),     32'd1);
        check({tag, "_noabrt"}, 32'(ab),      32'd0);
    endtask

    logic [3:0] amt_keys [10];
    int         n;
    int         cnt;
    bit         found;

    initial begin
        amt_keys = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
        rst        = 1'b0;
        card_valid = 1'b0;
        card_acc   = 4'd0;
        card_lang  = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_atm_rst", 32'(atm_rst), 32'd0);
        check("rst_prompt",  32'(prompt),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_result",  result_balance, 32'd0);
        check("rst_pin",     32'(atm_pin), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Balance enquiry, account 1
        insert(4'd1, 1'b1, 1'b0, 4'd0);
        check("t1_prompt_pin", 32'(prompt), 32'd1);
        check("t1_busy",       32'(busy),   32'd1);
        press4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        check("t1_prompt_op", 32'(prompt), 32'd2);
        press(4'd3);
        observe("t1", OP_BALANCE, 4'd1, 16'd1234, 16'd0, 32'd0);
        check("t1_lang",    32'(atm_language),   32'd1);
        check("t1_balance", result_balance,      32'd1500);
        check("t1_success", 32'(result_success), 32'd1);
        check("t1_idle",    32'(prompt),         32'd0);

        // Deposit 1000, account 2
        insert(4'd2, 1'b0, 1'b0, 4'd0);
        press4(4'd2, 4'd3, 4'd4, 4'd5);
        press(KEY_ENTER);
        press(4'd5);
        check("t2_prompt_amt", 32'(prompt), 32'd3);
        press4(4'd1, 4'd0, 4'd0, 4'd0);
        press(KEY_ENTER);
        observe("t2", OP_DEPOSIT, 4'd2, 16'd2345, 16'd0, 32'd1000);
        check("t2_balance", result_balance,      32'd3500);
        check("t2_success", 32'(result_success), 32'd1);

        // Short PIN ignored, fifth digit ignored, amount overflow
        insert(4'd1, 1'b0, 1'b0, 4'd0);
        press(4'd1); press(4'd2); press(KEY_ENTER);
        check("t3_short_pin", 32'(prompt), 32'd1);
        press(KEY_CLEAR);
        press4(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'd5);
        press(KEY_ENTER);
        check("t3_pin_ok", 32'(prompt), 32'd2);
        press(4'd4);
        for (int i = 0; i < 10; i++) begin
            press(amt_keys[i]);
            if (i == 8) check("t4_ovf_9dig", 32'(amt_overflow), 32'd0);
        end
        check("t4_ovf_set", 32'(amt_overflow), 32'd1);
        press(KEY_CLEAR);
        check("t4_ovf_sticky", 32'(amt_overflow), 32'd1);
        for (int i = 0; i < 10; i++) press(amt_keys[i]);
        press(KEY_ENTER);
        observe("t4", OP_WITHDRAW, 4'd1, 16'd1234, 16'd0, 32'd123456789);
        check("t4_balance", result_balance,      32'd1500);
        check("t4_success", 32'(result_success), 32'd0);

        // Change PIN, account 2
        insert(4'd2, 1'b0, 1'b0, 4'd0);
        press4(4'd2, 4'd3, 4'd4, 4'd5);
        press(KEY_ENTER);
        press(4'd6);
        check("tn_prompt_newpin", 32'(prompt), 32'd4);
        press4(4'd9, 4'd8, 4'd7, 4'd6);
        press(KEY_ENTER);
        observe("tn", OP_CHPIN, 4'd2, 16'd2345, 16'd9876, 32'd0);
        check("tn_balance", result_balance,      32'd2500);
        check("tn_success", 32'(result_success), 32'd1);

        // Cancel during amount entry
        insert(4'd1, 1'b0, 1'b0, 4'd0);
        press4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        press(4'd5);
        press(4'd7);
        press(KEY_CANCEL);
        check("t5_aborted", 32'(aborted), 32'd1);
        check("t5_busy",    32'(busy),    32'd0);
        cnt = 0;
        n   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (atm_rst) cnt++;
            if (aborted) n++;
        end
        check("t5_no_rst",   32'(cnt), 32'd0);
        check("t5_pulse1",   32'(n),   32'd0);
        check("t5_res_keep", result_balance,      32'd2500);
        check("t5_suc_keep", 32'(result_success), 32'd1);

        // Timeout in GET_OP
        insert(4'd1, 1'b0, 1'b0, 4'd0);
        press4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        n     = 0;
        found = 1'b0;
        for (int i = 1; i <= int'(TMO) + 20 && !found; i++) begin
            @(negedge clk);
            if (aborted) begin
                found = 1'b1;
                n     = i;
            end
        end
        check("t5_timeout", 32'(n), 32'(TMO));
        check("t5_tmo_prompt", 32'(prompt), 32'd0);

        // Reset during the hold window
        insert(4'd1, 1'b0, 1'b0, 4'd0);
        press4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_ENTER);
        press(4'd3);
        @(negedge clk);
        check("t6_in_wait", 32'(atm_rst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_atm",    32'(atm_rst), 32'd0);
        check("t6_rst_done",   32'(done),    32'd0);
        check("t6_rst_pin",    32'(atm_pin), 32'd0);
        check("t6_rst_busy",   32'(busy),    32'd0);
        check("t6_rst_result", result_balance, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || atm_rst) n++;
        end
        check("t6_no_done", 32'(n), 32'd0);

        // Card and key together in IDLE: only the card is taken
        insert(4'd2, 1'b0, 1'b1, 4'd9);
        press4(4'd2, 4'd3, 4'd4, 4'd5);
        press(KEY_ENTER);
        press(4'd3);
        observe("t6", OP_BALANCE, 4'd2, 16'd2345, 16'd0, 32'd0);
        check("t6_balance", result_balance,      32'd2500);
        check("t6_success", 32'(result_success), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Initiator-side front end for the ATM core: collects card, keypad digits and operation choice from the user.
- Assembles one request, presents it to the ATM request ports, releases the ATM from idle for a fixed hold window, then captures balance/success and reports the result.
- Sits between the user-facing keypad/card reader and the ATM core, replacing the bench-style direct port driving.

Parameters:
- HOLD_CYCLES, 4, cycles the request is held with atm_rst high before result capture (min 2).
- TIMEOUT_CYCLES, 1000, idle cycles allowed in any entry state before abort.
- AMT_DIGITS, 9, maximum decimal digits accepted for amount (999999999 < 2^32).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- card_valid  in  1  one-cycle strobe: card inserted; card_acc valid.
- card_acc  in  4  account number from card.
- card_lang  in  1  language preference from card.
- key_valid  in  1  one-cycle keypad strobe.
- key_code  in  4  0-9 digit, 10 ENTER, 11 CLEAR, 12 CANCEL, others ignored.
- atm_balance  in  32  ATM balance output.
- atm_success  in  1  ATM success output.
- atm_state  in  3  ATM state; used for debug only, no control use.
- atm_rst  out  1  ATM reset/enable; 0 holds the ATM in idle (state 7).
- atm_operation  out  3  ATM operation code.
- atm_acc_num  out  4  account.
- atm_pin  out  16  binary value of the 4-digit decimal PIN.
- atm_new_pin  out  16  binary value of the new PIN.
- atm_amount  out  32  binary value of the amount.
- atm_language  out  1  language.
- busy  out  1  high from card accept until done/aborted.
- prompt  out  3  expected input: 0 card, 1 PIN, 2 op, 3 amount, 4 new PIN, 5 wait.
- done  out  1  one-cycle pulse; result_* valid from this cycle.
- aborted  out  1  one-cycle pulse on cancel or timeout.
- result_success  out  1  captured atm_success.
- result_balance  out  32  captured atm_balance.
- amt_overflow  out  1  sticky per session: extra amount digits were dropped.

Behaviour:
- Reset, sampled at posedge with rst=0: every output is 0, including atm_rst=0, all atm_* fields, result_* and prompt; state goes to IDLE. A reset mid-session discards the session and produces no done or aborted pulse.
- States:
  - IDLE: card_valid latches acc and lang, clears accumulators and amt_overflow, goes to GET_PIN.
  - GET_PIN:
    - Digit: pin = pin*10 + d while fewer than 4 digits; further digits are ignored.
    - ENTER with exactly 4 digits goes to GET_OP; otherwise it is ignored.
    - CLEAR zeroes the value and the digit count.
  - GET_OP: digit 3 (balance) goes to ISSUE; 4 (withdraw) and 5 (deposit) go to GET_AMT; 6 (change PIN) goes to GET_NEWPIN. Digits 0-2 and 7-9, ENTER and CLEAR are ignored.
  - GET_AMT:
    - Digit: amt = amt*10 + d while fewer than AMT_DIGITS digits; beyond that the digit is dropped and amt_overflow is set.
    - ENTER goes to ISSUE. The amount may be 0.
    - CLEAR zeroes amt and the digit count; amt_overflow stays set.
  - GET_NEWPIN: same rules as GET_PIN, then goes to ISSUE.
  - ISSUE/WAIT:
    - atm_* fields are registered and stable for the whole window.
    - atm_rst=1 for exactly HOLD_CYCLES cycles.
    - On the last of these cycles, atm_balance and atm_success are captured into result_*.
    - The next cycle is REPORT.
    - key_valid and card_valid are ignored throughout.
  - REPORT: done=1 and atm_rst=0 for one cycle, then IDLE.
- CANCEL in GET_PIN, GET_OP, GET_AMT or GET_NEWPIN goes to IDLE and pulses aborted. No ATM request is issued; result_* keep their old values.
- Timeout: a counter clears on every key_valid and on each state change. Reaching TIMEOUT_CYCLES in an entry state aborts exactly as CANCEL does.
- Simultaneous events: key_valid and card_valid together in IDLE: only the card is taken. card_valid outside IDLE is ignored.
- Arithmetic: the multiply-by-10 accumulate is done in 34 bits and truncated to the field width. It cannot overflow within the digit limits; PIN max is 9999 (fits 16 bits).
- atm_language = latched card_lang.
- Latency: done asserts HOLD_CYCLES+1 cycles after the accepting key edge (ENTER, or op digit 3).

Decomposition:
- atm_pkg:
  - Op codes: OP_BALANCE=3, OP_WITHDRAW=4, OP_DEPOSIT=5, OP_CHPIN=6.
  - Key codes: KEY_ENTER=10, KEY_CLEAR=11, KEY_CANCEL=12.
  - Prompt encodings and the state enum.
  - ATM_IDLE_STATE=7.
- Sub-module atm_dec_accum:
  - Parameterised width and max digits.
  - Inputs: clear, digit strobe, digit.
  - Outputs: value, digit count, overflow.
  - Instantiated three times: PIN, new PIN, amount.

Test Plan:
1. Card acc=1, keys 1,2,3,4,ENTER,3 -> atm_rst high for exactly 4 cycles with op=3, acc=1, pin=1234; done pulse; result_balance equals the ATM balance for account 1.
2. Acc=2, PIN 2345, op 5, keys 1,0,0,0,ENTER -> atm_amount=1000, op=5; done; result_success=1.
3. PIN entry 1,2,3,4,5,ENTER -> atm_pin=1234 (5th digit ignored). Keys 1,2,ENTER in GET_PIN -> stays in GET_PIN, prompt=1.
4. Amount of 10 digits 1234567891 -> atm_amount=123456789, amt_overflow=1.
5. CANCEL in GET_AMT -> aborted pulse, atm_rst never rises, result_* unchanged. No key for TIMEOUT_CYCLES in GET_OP -> aborted.
6. rst=0 asserted during WAIT -> next cycle atm_rst=0, all outputs 0, no done pulse. After rst=1, a new card is accepted normally.
